spi_pwm_driver_n: RTL

- Parametrised SPI-controlled multi-channel PWM generator.
- A mode-0 SPI slave, oversampled by the system clock, writes per-channel duty levels into shadow registers.
- Shadow levels are copied into active registers only at a PWM period boundary, so outputs never glitch mid-period.
- Adds burst auto-increment addressing, a control register and full channel count, over the fixed 4-of-7-channel generation.

---
 rtl/spi_pwm_pkg.sv | 17 +
 rtl/spi_byte_slave.sv | 100 ++++++++++
 rtl/spi_pwm_driver_n.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/spi_pwm_pkg.sv
// Shared constants and types for the SPI-controlled PWM driver.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spi_pwm_pkg;

    localparam int         CMD_WR_BIT  = 7;      // command byte: 1 = write, 0 = read
    localparam logic [6:0] CTRL_ADDR   = 7'h7F;  // control register address
    localparam int         CTRL_EN_BIT = 0;      // CTRL bit that gates all outputs

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WR,
        RD
    } spi_state_e;

endpackage

// File: rtl/spi_byte_slave.sv
// Mode-0 SPI byte slave oversampled by clk: synchronizers, sclk edge detect, rx byte, tx shift.
// Latency: byte_done_o fires SYNC_STAGES clk cycles after the 8th sclk rise; tx bit appears 1 clk after a detected fall.
// Backpressure: none; the SPI master owns timing (sclk phases >= SYNC_STAGES+2 clk cycles).
// Ports: clk/reset (sync, active-high); sclk_i/cs_n_i/mosi_i raw SPI pins; cs_fall_o/cs_rise_o chip-select edge pulses;
//        byte_done_o/rx_byte_o completed byte (valid for the single pulse cycle);
//        with SPI_READBACK_EN: tx_dat_i byte to send, tx_load_o load strobe, miso_o shift MSB.
module spi_byte_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sclk_i,
    input  logic       cs_n_i,
    input  logic       mosi_i,
`ifdef SPI_READBACK_EN
    input  logic [7:0] tx_dat_i,
    output logic       tx_load_o,
    output logic       miso_o,
`endif
    output logic       cs_fall_o,
    output logic       cs_rise_o,
    output logic       byte_done_o,
    output logic [7:0] rx_byte_o
);

    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;
    logic                   cs_prev_q;
    logic [2:0]             bit_cnt_q;
    logic [6:0]             rx_q;

    logic sclk_s, cs_s, mosi_s, sclk_rise;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s      = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;

    assign cs_fall_o   = ~cs_s & cs_prev_q;
    assign cs_rise_o   = cs_s & ~cs_prev_q;
    // All three pins share the same sync depth, so mosi is already stable when the rise is seen.
    assign byte_done_o = sclk_rise & ~cs_s & (bit_cnt_q == 3'd7);
    assign rx_byte_o   = {rx_q, mosi_s};

    always_ff @(posedge clk) begin
        if (reset) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 7'd0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n_i};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            // Deselect throws away any partial byte.
            if (cs_s) begin
                bit_cnt_q <= 3'd0;
            end else if (sclk_rise) begin
                bit_cnt_q <= bit_cnt_q + 3'd1;
                rx_q      <= {rx_q[5:0], mosi_s};
            end
        end
    end

`ifdef SPI_READBACK_EN
    logic       sclk_fall;
    logic       load_pend_q;
    logic [7:0] tx_q;

    assign sclk_fall = ~sclk_s & sclk_prev_q;
    // The falling edge after each completed byte reloads; every other falling edge shifts.
    assign tx_load_o = sclk_fall & load_pend_q & ~cs_s;
    assign miso_o    = tx_q[7];

    always_ff @(posedge clk) begin
        if (reset) begin
            load_pend_q <= 1'b0;
            tx_q        <= 8'h00;
        end else if (cs_s) begin
            load_pend_q <= 1'b0;
            tx_q        <= 8'h00;
        end else if (byte_done_o) begin
            load_pend_q <= 1'b1;
        end else if (tx_load_o) begin
            load_pend_q <= 1'b0;
            tx_q        <= tx_dat_i;
        end else if (sclk_fall) begin
            tx_q        <= {tx_q[6:0], 1'b0};
        end
    end
`endif

endmodule

// File: rtl/spi_pwm_driver_n.sv
// SPI-programmed NUM_CH-channel PWM; shadow levels move to active levels only at the period wrap.
// Latency: pwm_out is registered, one clk after the counter value it reflects; new levels apply from the next period.
// Backpressure: none; SPI master paces transfers, PWM free-runs.
// Ports: clk, reset (sync, active-high); sclk/cs_n/mosi/miso mode-0 SPI slave; pwm_out[NUM_CH] outputs;
//        period_start one-cycle pulse while the counter is 0.
// Build option: define SPI_READBACK_EN to build the read path (otherwise reads are ignored and miso is 0).
module spi_pwm_driver_n
    import spi_pwm_pkg::*;
#(
    parameter int NUM_CH      = 7,
    parameter int PWM_BITS    = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              period_start
);

    localparam int                  IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [PWM_BITS-1:0] CNT_MAX = PWM_BITS'((1 << PWM_BITS) - 2);

    logic                cs_fall, cs_rise, byte_done;
    logic [7:0]          rx_byte;
    spi_state_e          state_q, state_d;
    logic [6:0]          addr_q, addr_d, addr_inc;
    logic [PWM_BITS-1:0] cnt_q, cnt_d;
    logic [PWM_BITS-1:0] shadow_q [NUM_CH];
    logic [PWM_BITS-1:0] active_q [NUM_CH];
    logic                ctrl_en_q;
    logic [NUM_CH-1:0]   pwm_q;
    logic                period_q;
    logic                wrap, wr_en, addr_is_ch;
    logic [IDX_W-1:0]    ch_idx;

    assign wrap       = (cnt_q == CNT_MAX);
    assign cnt_d      = wrap ? '0 : cnt_q + PWM_BITS'(1);
    assign addr_inc   = (addr_q == CTRL_ADDR) ? CTRL_ADDR : addr_q + 7'd1;
    assign addr_is_ch = (int'(addr_q) < NUM_CH);
    assign ch_idx     = addr_q[IDX_W-1:0];

`ifdef SPI_READBACK_EN
    logic       tx_load, tx_msb;
    logic [7:0] rd_dat;

    always_comb begin
        rd_dat = 8'h00;
        if (addr_is_ch) begin
            rd_dat = 8'(shadow_q[ch_idx]);
        end else if (addr_q == CTRL_ADDR) begin
            rd_dat[CTRL_EN_BIT] = ctrl_en_q;
        end
    end

    assign miso = (state_q == RD) & tx_msb;
`else
    assign miso = 1'b0;
`endif

    spi_byte_slave #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_spi (
        .clk         (clk),
        .reset       (reset),
        .sclk_i      (sclk),
        .cs_n_i      (cs_n),
        .mosi_i      (mosi),
`ifdef SPI_READBACK_EN
        .tx_dat_i    (rd_dat),
        .tx_load_o   (tx_load),
        .miso_o      (tx_msb),
`endif
        .cs_fall_o   (cs_fall),
        .cs_rise_o   (cs_rise),
        .byte_done_o (byte_done),
        .rx_byte_o   (rx_byte)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE: if (cs_fall) state_d = CMD;
            CMD: begin
                if (byte_done) begin
                    addr_d  = rx_byte[6:0];
                    state_d = rx_byte[CMD_WR_BIT] ? WR : RD;
                end
            end
            WR: begin
                if (byte_done) begin
                    wr_en  = 1'b1;
                    addr_d = addr_inc;
                end
            end
            RD: begin
`ifdef SPI_READBACK_EN
                // Address advances as each read byte is captured into the shifter.
                if (tx_load) addr_d = addr_inc;
`endif
            end
            default: state_d = IDLE;
        endcase
        if (cs_rise) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= 7'd0;
            cnt_q     <= '0;
            ctrl_en_q <= 1'b1;
            pwm_q     <= '0;
            period_q  <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            period_q <= wrap;
            // Nonblocking copy: a write landing on the wrap cycle reaches active one period later.
            if (wrap) begin
                for (int i = 0; i < NUM_CH; i++) active_q[i] <= shadow_q[i];
            end
            if (wr_en && addr_is_ch) shadow_q[ch_idx] <= rx_byte[PWM_BITS-1:0];
            if (wr_en && (addr_q == CTRL_ADDR)) ctrl_en_q <= rx_byte[CTRL_EN_BIT];
            for (int i = 0; i < NUM_CH; i++) begin
                pwm_q[i] <= (cnt_q < active_q[i]) & ctrl_en_q;
            end
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = period_q;

endmodule
